// File: rtl/mem_byte_master_if.sv
// Request/response and byte-RAM port bundle for mem_byte_master.
// master = the memory-stage block; slave = pipeline plus RAM side.
interface mem_byte_master_if #(
    parameter int ADDR_W = 13
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_byte_master.sv
// Splits one RV32I load/store into 1/2/4 little-endian byte RAM accesses.
// Latency: store N+1, load N+2, error 1; accepts only in IDLE, response is an unstalled pulse.
module mem_byte_master #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    mem_byte_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        last_q;
    logic              we_q;
    logic              err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;

    logic              accept;
    logic              f3_legal;
    logic              req_err;
    logic [1:0]        req_last;
    logic              unused_addr_hi;

    assign accept         = bus.req_valid && (state == IDLE);
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    always_comb begin
        f3_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !bus.req_we;
            default:                f3_legal = 1'b0;
        endcase
        req_err = !f3_legal
               || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
               || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        // index of the final byte: 0 for B/BU, 1 for H/HU, 3 for W
        req_last = bus.req_funct3[1] ? 2'd3 : (bus.req_funct3[0] ? 2'd1 : 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
            ACCESS:  if (cnt == last_q) state_nxt = we_q ? RESP : DRAIN;
            DRAIN:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 2'd0;
            last_q  <= 2'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= 2'd0;
                        last_q  <= req_last;
                        we_q    <= bus.req_we;
                        err_q   <= req_err;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr[ADDR_W-1:0];
                        wdata_q <= bus.req_wdata;
                        data_q  <= 32'd0;
                    end
                end
                ACCESS: begin
                    // read data trails the address by one cycle
                    if (!we_q && cnt != 2'd0)
                        data_q[{2'(cnt - 2'd1), 3'b000} +: 8] <= bus.mem_rdata;
                    if (cnt != last_q)
                        cnt <= cnt + 2'd1;
                end
                DRAIN: data_q[{last_q, 3'b000} +: 8] <= bus.mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = 32'd0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'd0;
        case (state)
            ACCESS: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q + ADDR_W'(cnt);
                bus.mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                if (!err_q && !we_q) begin
                    case (f3_q)
                        3'b000:  bus.rsp_rdata = {{24{data_q[7]}}, data_q[7:0]};
                        3'b100:  bus.rsp_rdata = {24'd0, data_q[7:0]};
                        3'b001:  bus.rsp_rdata = {{16{data_q[15]}}, data_q[15:0]};
                        3'b101:  bus.rsp_rdata = {16'd0, data_q[15:0]};
                        3'b010:  bus.rsp_rdata = data_q;
                        default: bus.rsp_rdata = 32'd0;
                    endcase
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_byte_master.sv
// Directed bench for mem_byte_master against a 1-cycle-latency byte RAM model.
module tb_mem_byte_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_byte_master_if #(.ADDR_W(13)) bus ();

    mem_byte_master #(.ADDR_W(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [7:0] ram [0:8191];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          en;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err,
                           output logic [31:0] rdata, output int en_cnt);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        lat = 0; en_cnt = 0; err = 1'b0; rdata = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.mem_en) en_cnt++;
            if (bus.rsp_valid) begin
                lat   = c;
                err   = bus.rsp_err;
                rdata = bus.rsp_rdata;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          en_cnt;
        int          rsp1;
        int          rsp2;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] rd2;
        logic [2:0]  rdy;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        //         we    f3      addr           wdata          err   rdata          lat en
        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hA1B2_C3D4, 1'b0, 32'h0000_0000, 5, 4};
        vecs[1]  = '{1'b1, 3'b010, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0000_0000, 5, 4};
        vecs[2]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hA1B2_C3D4, 6, 4};
        vecs[3]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FFA1, 3, 1};
        vecs[4]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_00A1, 3, 1};
        vecs[5]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_A1B2, 4, 2};
        vecs[6]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_A1B2, 4, 2};
        vecs[7]  = '{1'b0, 3'b010, 32'h0000_0011, 32'h0,         1'b1, 32'h0000_0000, 1, 0};
        vecs[8]  = '{1'b1, 3'b001, 32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1, 0};
        vecs[9]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000, 1, 0};
        vecs[10] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1, 0};
        vecs[11] = '{1'b0, 3'b010, 32'h0000_0012, 32'h0,         1'b1, 32'h0000_0000, 1, 0};
        vecs[12] = '{1'b1, 3'b001, 32'h0000_0020, 32'hDEAD_7F80, 1'b0, 32'h0000_0000, 3, 2};
        vecs[13] = '{1'b0, 3'b001, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_7F80, 4, 2};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_0020, 32'h0,         1'b0, 32'hFFFF_FF80, 3, 1};
        vecs[15] = '{1'b0, 3'b100, 32'h0000_0021, 32'h0,         1'b0, 32'h0000_007F, 3, 1};
        vecs[16] = '{1'b0, 3'b101, 32'h0000_0021, 32'h0,         1'b1, 32'h0000_0000, 1, 0};
        vecs[17] = '{1'b1, 3'b000, 32'h0000_1FFF, 32'h1234_565A, 1'b0, 32'h0000_0000, 2, 1};
        vecs[18] = '{1'b0, 3'b000, 32'h0000_1FFF, 32'h0,         1'b0, 32'h0000_005A, 3, 1};
        vecs[19] = '{1'b0, 3'b100, 32'h0000_3FFF, 32'h0,         1'b0, 32'h0000_005A, 3, 1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst rsp_rdata", bus.rsp_rdata,      32'd0);
        check("rst mem_en",    32'(bus.mem_en),    32'd0);
        check("rst mem_we",    32'(bus.mem_we),    32'd0);
        check("rst mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, err, rdata, en_cnt);
            check($sformatf("v%0d latency", i), 32'(lat),    32'(vecs[i].lat));
            check($sformatf("v%0d err", i),     32'(err),    32'(vecs[i].err));
            check($sformatf("v%0d rdata", i),   rdata,       vecs[i].rdata);
            check($sformatf("v%0d en_cycles", i), 32'(en_cnt), 32'(vecs[i].en));
            @(negedge clk);
            check($sformatf("v%0d pulse_end", i), 32'(bus.rsp_valid), 32'd0);
            check($sformatf("v%0d rdata_idle", i), bus.rsp_rdata,     32'd0);
            check($sformatf("v%0d ready_back", i), 32'(bus.req_ready), 32'd1);
            if (i == 0) begin
                check("sw byte 0x10", 32'(ram[13'h010]), 32'hD4);
                check("sw byte 0x11", 32'(ram[13'h011]), 32'hC3);
                check("sw byte 0x12", 32'(ram[13'h012]), 32'hB2);
                check("sw byte 0x13", 32'(ram[13'h013]), 32'hA1);
            end
        end

        // back-to-back: SB then LB with req_valid held high throughout
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0000_1FFF;
        bus.req_wdata  = 32'h0000_00C3;
        @(posedge clk);
        rsp1 = 0; rsp2 = 0; rd2 = 32'd0; en_cnt = 0; rdy = 3'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 3) rdy[c-1] = bus.req_ready;
            if (bus.mem_en) en_cnt++;
            if (bus.rsp_valid) begin
                if (rsp1 == 0) rsp1 = c;
                else begin rsp2 = c; rd2 = bus.rsp_rdata; end
            end
            if (c == 1) begin
                bus.req_we    = 1'b0;
                bus.req_wdata = 32'd0;
            end
            if (c == 4) bus.req_valid = 1'b0;
        end
        check("b2b ready c1", 32'(rdy[0]), 32'd0);
        check("b2b ready c2", 32'(rdy[1]), 32'd0);
        check("b2b ready c3", 32'(rdy[2]), 32'd1);
        check("b2b rsp1 cycle", 32'(rsp1), 32'd2);
        check("b2b rsp2 cycle", 32'(rsp2), 32'd6);
        check("b2b lb rdata", rd2, 32'hFFFF_FFC3);
        check("b2b en cycles", 32'(en_cnt), 32'd2);

        // reset during the second byte of a SW
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0040;
        bus.req_wdata  = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort en at cnt1", 32'(bus.mem_en), 32'd1);
        check("abort addr at cnt1", 32'(bus.mem_addr), 32'h41);
        rst = 1'b1;
        @(negedge clk);
        check("abort ready", 32'(bus.req_ready), 32'd1);
        check("abort mem_en", 32'(bus.mem_en), 32'd0);
        check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        rsp1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_en) rsp1++;
        end
        check("abort no activity", 32'(rsp1), 32'd0);
        check("abort byte 0x40", 32'(ram[13'h040]), 32'h44);
        check("abort byte 0x41", 32'(ram[13'h041]), 32'h33);
        check("abort byte 0x42", 32'(ram[13'h042]), 32'h00);
        check("abort byte 0x43", 32'(ram[13'h043]), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
